// File: rtl/data_mem_arbiter_if.sv
// Two-requester data-memory bus plus the single-port RAM side it is arbitrated onto.
// Signal names keep the requester/RAM port names so the bus reads like the block's pin list.
interface data_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  m0_req_i;
    logic                  m0_we_i;
    logic [BE_W-1:0]       m0_be_i;
    logic [ADDR_WIDTH-1:0] m0_addr_i;
    logic [DATA_WIDTH-1:0] m0_wdata_i;
    logic                  m0_gnt_o;
    logic                  m0_rvalid_o;
    logic [DATA_WIDTH-1:0] m0_rdata_o;

    logic                  m1_req_i;
    logic                  m1_we_i;
    logic [BE_W-1:0]       m1_be_i;
    logic [ADDR_WIDTH-1:0] m1_addr_i;
    logic [DATA_WIDTH-1:0] m1_wdata_i;
    logic                  m1_gnt_o;
    logic                  m1_rvalid_o;
    logic [DATA_WIDTH-1:0] m1_rdata_o;

    logic                  ram_en_o;
    logic [BE_W-1:0]       ram_we_o;
    logic [ADDR_WIDTH-3:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the load/store unit (m0)
// and the debug/DMA port (m1); grant is combinational, read data returns one cycle later.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk_i,
    input  logic rstn_i,
    data_mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  r_last_gnt;
    logic                  r_rd_pend;
    logic                  r_rd_owner;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_sel_we;
    logic [BE_W-1:0]       w_sel_be;
    logic [ADDR_WIDTH-3:0] w_sel_word;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_rvalid0;
    logic                  w_rvalid1;
    logic [3:0]            w_unused_addr_lo;

    // The RAM is word-addressed, so the byte offset bits never reach it.
    assign w_unused_addr_lo = {bus.m0_addr_i[1:0], bus.m1_addr_i[1:0]};

    // Ties go to whichever master did not win last; reset leaves last_gnt=1 so m0 wins first.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rstn_i) begin
            if (bus.m0_req_i && (!bus.m1_req_i || r_last_gnt)) begin
                w_gnt0 = 1'b1;
            end else if (bus.m1_req_i) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_gnt0 | w_gnt1;

    // With no grant the mux rests on master 0 so the RAM address/data lines stay quiet.
    always_comb begin
        w_sel_we    = bus.m0_we_i;
        w_sel_be    = bus.m0_be_i;
        w_sel_word  = bus.m0_addr_i[ADDR_WIDTH-1:2];
        w_sel_wdata = bus.m0_wdata_i;
        if (w_gnt1) begin
            w_sel_we    = bus.m1_we_i;
            w_sel_be    = bus.m1_be_i;
            w_sel_word  = bus.m1_addr_i[ADDR_WIDTH-1:2];
            w_sel_wdata = bus.m1_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last_gnt <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_last_gnt <= w_gnt1;
            end
            r_rd_pend  <= w_any_gnt && !w_sel_we;
            r_rd_owner <= w_gnt1;
        end
    end

    assign w_rvalid0 = r_rd_pend && !r_rd_owner;
    assign w_rvalid1 = r_rd_pend &&  r_rd_owner;

    assign bus.m0_gnt_o    = w_gnt0;
    assign bus.m1_gnt_o    = w_gnt1;
    assign bus.m0_rvalid_o = w_rvalid0;
    assign bus.m1_rvalid_o = w_rvalid1;
    assign bus.m0_rdata_o  = w_rvalid0 ? bus.ram_rdata_i : '0;
    assign bus.m1_rdata_o  = w_rvalid1 ? bus.ram_rdata_i : '0;

    assign bus.ram_en_o    = w_any_gnt;
    assign bus.ram_we_o    = (w_any_gnt && w_sel_we) ? w_sel_be : '0;
    assign bus.ram_addr_o  = w_sel_word;
    assign bus.ram_wdata_o = w_sel_wdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a reference model predicts grants and RAM contents,
// queues expected read returns, and a separate monitor checks every rvalid against that queue.
module tb_data_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int NW = 16;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    typedef struct {
        logic          req;
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    op_t q0[$];
    op_t q1[$];
    rd_t exp_q[$];
    logic [DW-1:0] ram_mem [NW];
    logic [DW-1:0] shadow [NW];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic s_gnt0 = 1'b0;
    logic s_gnt1 = 1'b0;
    logic m_last = 1'b1;
    bit drop_en = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic op_t mk(logic we, logic [BW-1:0] be, logic [AW-1:0] addr, logic [DW-1:0] wd);
        op_t o;
        o.req = 1'b1;
        o.we = we;
        o.be = be;
        o.addr = addr;
        o.wdata = wd;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.req = ($urandom_range(0, 3) != 0);
        o.we = 1'($urandom_range(0, 1));
        o.be = 4'($urandom_range(0, 15));
        o.addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        o.wdata = $urandom;
        return o;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural single-port RAM: byte-strobed write, registered read of the pre-write word.
    always @(posedge clk_i) begin
        if (bus.ram_en_o) begin
            for (int b = 0; b < BW; b++) begin
                if (bus.ram_we_o[b]) ram_mem[bus.ram_addr_o[3:0]][b*8 +: 8] <= bus.ram_wdata_o[b*8 +: 8];
            end
            bus.ram_rdata_i <= ram_mem[bus.ram_addr_o[3:0]];
        end
    end

    task automatic load0();
        op_t o;
        o = '{default: '0};
        if (q0.size() > 0) o = q0.pop_front();
        bus.m0_req_i = o.req; bus.m0_we_i = o.we; bus.m0_be_i = o.be;
        bus.m0_addr_i = o.addr; bus.m0_wdata_i = o.wdata;
    endtask

    task automatic load1();
        op_t o;
        o = '{default: '0};
        if (q1.size() > 0) o = q1.pop_front();
        bus.m1_req_i = o.req; bus.m1_we_i = o.we; bus.m1_be_i = o.be;
        bus.m1_addr_i = o.addr; bus.m1_wdata_i = o.wdata;
    endtask

    // Driver: a master holds its request until granted, then moves to its next queued op.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (!bus.m0_req_i || s_gnt0 || (drop_en && $urandom_range(0, 15) == 0)) load0();
            if (!bus.m1_req_i || s_gnt1 || (drop_en && $urandom_range(0, 15) == 0)) load1();
        end
    end

    // Reference model: predicts grants and RAM port, updates the shadow memory in grant order.
    initial begin
        logic e0, e1, we;
        logic [BW-1:0] be;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int w;
        forever begin
            @(negedge clk_i);
            s_gnt0 = bus.m0_gnt_o;
            s_gnt1 = bus.m1_gnt_o;
            if (!rstn_i) begin
                chk("rst_gnt", {bus.m0_gnt_o, bus.m1_gnt_o}, 0);
                chk("rst_ram_en_we", {bus.ram_en_o, bus.ram_we_o}, 0);
                chk("rst_rvalid", {bus.m0_rvalid_o, bus.m1_rvalid_o}, 0);
                chk("rst_rdata", {bus.m0_rdata_o, bus.m1_rdata_o}, 0);
                exp_q.delete();
                m_last = 1'b1;
            end else begin
                e0 = bus.m0_req_i && (!bus.m1_req_i || m_last);
                e1 = bus.m1_req_i && !e0;
                chk("gnt", {bus.m0_gnt_o, bus.m1_gnt_o}, {e0, e1});
                we = e1 ? bus.m1_we_i : bus.m0_we_i;
                be = e1 ? bus.m1_be_i : bus.m0_be_i;
                a  = e1 ? bus.m1_addr_i : bus.m0_addr_i;
                wd = e1 ? bus.m1_wdata_i : bus.m0_wdata_i;
                chk("ram_en", bus.ram_en_o, e0 | e1);
                chk("ram_we", bus.ram_we_o, ((e0 | e1) && we) ? be : 4'h0);
                chk("ram_addr", bus.ram_addr_o, a >> 2);
                chk("ram_wdata", bus.ram_wdata_o, wd);
                if (e0 || e1) begin
                    m_last = e1;
                    w = int'(a[5:2]);
                    if (we) begin
                        for (int b = 0; b < BW; b++) if (be[b]) shadow[w][b*8 +: 8] = wd[b*8 +: 8];
                    end else begin
                        exp_q.push_back('{owner: (e1 ? 1 : 0), data: shadow[w], due: cyc + 1});
                    end
                end
            end
        end
    end

    // Monitor: every read return is matched against the oldest expected read.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk_i);
            if (rstn_i) begin
                if (bus.m0_rvalid_o || bus.m1_rvalid_o) begin
                    chk("rvalid_onehot", bus.m0_rvalid_o & bus.m1_rvalid_o, 0);
                    if (exp_q.size() == 0) begin
                        chk("rvalid_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_owner", bus.m1_rvalid_o, e.owner);
                        chk("rd_latency", cyc, e.due);
                        chk("rd_data", (e.owner == 1) ? bus.m1_rdata_o : bus.m0_rdata_o, e.data);
                        chk("rd_other_zero", (e.owner == 1) ? bus.m0_rdata_o : bus.m1_rdata_o, 0);
                    end
                end else begin
                    chk("rdata_idle", {bus.m0_rdata_o, bus.m1_rdata_o}, 0);
                    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                        chk("rd_missing", 0, 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drain(string name, int limit);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || bus.m0_req_i || bus.m1_req_i) && n < limit) begin
            @(posedge clk_i);
            n++;
        end
        chk({name, "_drain"}, n < limit, 1);
        repeat (3) @(posedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_be_i = 0; bus.m0_addr_i = 0; bus.m0_wdata_i = 0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_be_i = 0; bus.m1_addr_i = 0; bus.m1_wdata_i = 0;
        bus.ram_rdata_i = 0;
        for (int i = 0; i < NW; i++) begin
            ram_mem[i] = '0;
            shadow[i] = '0;
        end

        // Requests pending during reset must not be granted.
        q0.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        q1.push_back(mk(1'b1, 4'hF, 32'h3C, 32'h1234_5678));
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        drain("reset_pending", 50);

        q0.push_back(mk(1'b1, 4'hF, 32'h0, 32'd13));
        q0.push_back(mk(1'b1, 4'hF, 32'h4, 32'd13));
        drain("two_writes", 50);
        chk("ram_word0", ram_mem[0], 32'd13);
        chk("ram_word1", ram_mem[1], 32'd13);
        q0.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        q0.push_back(mk(1'b0, 4'h0, 32'h4, 32'h0));
        drain("readback", 50);

        // Continuous reads from both masters starting at reset release.
        @(posedge clk_i);
        #1 rstn_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
            q1.push_back(mk(1'b0, 4'h0, 32'h4, 32'h0));
        end
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        drain("alt_reads", 100);

        q1.push_back(mk(1'b1, 4'b0101, 32'h8, 32'hAABB_CCDD));
        drain("partial_write", 50);
        chk("ram_word2_partial", ram_mem[2], 32'h00BB_00DD);

        q0.push_back(mk(1'b1, 4'hF, 32'h8, 32'd5));
        q1.push_back(mk(1'b0, 4'h0, 32'h8, 32'h0));
        drain("same_cycle_rw", 50);

        // Reset lands with an m0 read in flight; the read must vanish.
        q0.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0));
        k = 0;
        while (!s_gnt0 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        chk("inflight_gnt_seen", s_gnt0, 1);
        @(posedge clk_i);
        #1 rstn_i = 1'b0;
        q1.push_back(mk(1'b0, 4'h0, 32'h4, 32'h0));
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        drain("post_reset_read", 50);

        for (int i = 0; i < 5; i++) q1.push_back(mk(1'b0, 4'h0, {26'd0, 4'(i), 2'd0}, 32'h0));
        drain("m1_only", 50);

        drop_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            q0.push_back(rnd_op());
            q1.push_back(rnd_op());
        end
        drain("random", 6000);
        drop_en = 1'b0;
        repeat (3) @(posedge clk_i);
        chk("queue_empty_at_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
